// File: rtl/snd_mixer_n.sv
// ---------------------------------------------------------------------------
// snd_mixer_n - time-multiplexed N-channel audio mixer.
//
// A sample_cen strobe snapshots every channel input and every gain register,
// then one shared multiplier walks the channels at one channel per clock.
// The scaled sum is emitted as one registered sample.
//
// Handshake: snd_valid is a single-cycle pulse. snd_out is valid in that
// cycle and holds until the next pulse. sample_cen has no ready; it is
// accepted only while busy is low and is dropped otherwise (not queued).
//
// Optional feature macro: SND_MIX_CLAMP_EN. When defined, the output
// saturates to the OUT_W signed range. When undefined, the output keeps the
// low OUT_W bits (two's-complement wrap).
//
// Ports:
//   clk_sys     - system clock (only clock)
//   reset_n     - synchronous active-low reset
//   sample_cen  - one-cycle strobe that starts a mix pass
//   snd_in      - CHANNELS packed signed samples, channel i at [i*IN_W +: IN_W]
//   gain_we     - gain register write enable
//   gain_sel    - channel index for the gain write (>= CHANNELS ignored)
//   gain_din    - unsigned gain, unity = 2^(GAIN_W-1)
//   snd_out     - signed mixed sample, held between passes
//   snd_valid   - one-cycle pulse when snd_out updates
//   busy        - high while a pass is in progress
// ---------------------------------------------------------------------------
module snd_mixer_n #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 16,
    parameter int GAIN_W   = 8,
    parameter int OUT_W    = 19,
    localparam int SEL_W   = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       sample_cen,
    input  logic [CHANNELS*IN_W-1:0]   snd_in,
    input  logic                       gain_we,
    input  logic [SEL_W-1:0]           gain_sel,
    input  logic [GAIN_W-1:0]          gain_din,
    output logic signed [OUT_W-1:0]    snd_out,
    output logic                       snd_valid,
    output logic                       busy
);

    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(CHANNELS + 1);
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << (GAIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        [GAIN_W-1:0] gain      [CHANNELS];
    logic        [GAIN_W-1:0] snap_gain [CHANNELS];
    logic signed [IN_W-1:0]   snap_in   [CHANNELS];
    logic signed [ACC_W-1:0]  acc;
    logic        [SEL_W-1:0]  ch;

    logic                     last_ch;
    logic signed [PROD_W-1:0] in_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         fit_val;

    assign last_ch = (int'(ch) == CHANNELS - 1);
    assign busy    = (state_q != S_IDLE);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_cen) state_d = S_ACC;
            S_ACC:   if (last_ch)    state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shared multiplier: signed sample times zero-extended gain.
    always_comb begin
        in_ext   = PROD_W'(snap_in[ch]);
        gain_ext = PROD_W'({1'b0, snap_gain[ch]});
        prod     = in_ext * gain_ext;
    end

`ifdef SND_MIX_CLAMP_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> (GAIN_W - 1);
        if (shifted > OUT_MAX) begin
            fit_val = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            fit_val = OUT_MIN[OUT_W-1:0];
        end else begin
            fit_val = shifted[OUT_W-1:0];
        end
    end
`else
    // The low OUT_W bits of (acc >>> (GAIN_W-1)) are simply this slice of
    // acc; the accumulator is always wide enough for the slice.
    always_comb begin
        fit_val = acc[GAIN_W-1 +: OUT_W];
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc       <= '0;
            ch        <= '0;
            snd_out   <= '0;
            snd_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                gain[i]      <= GAIN_UNITY;
                snap_gain[i] <= GAIN_UNITY;
                snap_in[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            snd_valid <= 1'b0;

            // Gain write lands on the same edge as a capture; the snapshot
            // below reads the pre-write value, so that pass sees the old gain.
            if (gain_we && (int'(gain_sel) < CHANNELS)) begin
                gain[gain_sel] <= gain_din;
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_cen) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            snap_in[i]   <= snd_in[i*IN_W +: IN_W];
                            snap_gain[i] <= gain[i];
                        end
                        acc <= '0;
                        ch  <= '0;
                    end
                end
                S_ACC: begin
                    acc <= acc + ACC_W'(prod);
                    ch  <= last_ch ? '0 : ch + SEL_W'(1);
                end
                S_OUT: begin
                    snd_out   <= fit_val;
                    snd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
